xor4x4_share_arbiter: RTL and testbench
=======================================

// Module: xor4x4_share_arbiter
// PURPOSE
//  Shares one 4-lane, 4-input XOR reducer (O[k] = I0[k]^I1[k]^I2[k]^I3[k]) between NREQ requesters.
//  Round-robin arbitration with bounded burst ownership; one registered result slot with valid/ready backpressure.
//  Sits in front of the parity/checksum datapath; result is tagged with the winning requester index.
// PARAMETERS
//  NREQ      4  number of requesters, 2..8
//  IDW       2  width of out_id, = clog2(NREQ)
//  MAXBURST  4  max consecutive grants to one requester before forced rotation, 1..15
// PORTS
//  CLK          in   1        rising-edge clock
//  ASYNCRESETN  in   1        asynchronous active-low reset
//  req_valid    in   NREQ     requester i presents an operand set
//  req_ready    out  NREQ     one-hot grant; transfer on req_valid[i] & req_ready[i]
//  req_data     in   NREQ*16  requester i slice [16i+15:16i] = {I3,I2,I1,I0}, each 4 bits
//  out_valid    out  1        result slot full
//  out_ready    in   1        consumer accepts; slot drains on out_valid & out_ready
//  out_data     out  4        registered XOR reduction of accepted operand set
//  out_id       out  IDW      index of requester that produced out_data
//  out_burst    out  1        high when out_data belongs to an ongoing burst (>=2nd beat)
// BEHAVIOUR
//  Reset (async assert, sync deassert expected): out_valid=0, out_data=0, out_id=0, out_burst=0,
//    rr pointer=0, state=IDLE, burst count=0. req_ready low during reset.
//  can_accept = ~out_valid | out_ready (slot empty, or draining this cycle).
//  req_ready is combinational from req_valid, state and can_accept; at most one bit high; never high
//    when can_accept=0 or the matching req_valid=0.
//  FSM states:
//   IDLE: winner = first i with req_valid[i] searching from ptr upward modulo NREQ.
//     On transfer: load slot, ptr<=winner+1 mod NREQ, owner<=winner, cnt<=1;
//     go BURST if MAXBURST>1, else stay IDLE.
//   BURST: only owner eligible. On owner transfer: cnt<=cnt+1, out_burst<=1; if cnt+1==MAXBURST go IDLE.
//     If req_valid[owner]=0 in a cycle with can_accept=1 -> IDLE (no grant that cycle; one cycle of arbitration bubble).
//     If can_accept=0 the FSM holds state; owner keeps ownership through backpressure.
//  Latency: transfer in cycle n -> out_valid/out_data/out_id valid from cycle n+1. Throughput 1/cycle.
//  Slot: load and drain in the same cycle -> slot reloads, out_valid stays 1. Drain without load -> out_valid<=0.
//    out_data/out_id/out_burst hold while out_valid & ~out_ready.
//  out_burst<=0 on any IDLE-state transfer.
//  Requesters must hold req_valid/req_data stable until the transfer; arbiter does not check.
//  ptr only advances on IDLE-state grants; pointer wrap NREQ-1 -> 0.
//  Reset mid-burst: all state cleared immediately; no partial result emitted.
// TESTING
//  1. Single requester: req_valid=4'b0001, data 16'h1234, out_ready=1 -> next cycle out_valid=1, out_data=4'h4 (1^2^3^4), out_id=0.
//  2. All four requesters valid, MAXBURST=1, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; out_id sequence matches.
//  3. Req 2 holds valid for 6 beats, others valid, MAXBURST=4 -> beats 1-4 from id 2 (out_burst 0,1,1,1), then id 3 wins, id 2 resumes after rotation.
//  4. Backpressure: out_ready=0 for 3 cycles with slot full -> req_ready all 0, out_data/out_id stable; out_ready=1 -> drain + reload in same cycle, no beat lost or duplicated.
//  5. Owner drops valid mid-burst -> one idle cycle, then round-robin from ptr; data 16'hFFFF -> out_data 4'h0, 16'h000F -> 4'hF.
//  6. ASYNCRESETN pulsed low mid-burst between clock edges -> out_valid=0 immediately; after release first grant goes to lowest valid index.

Source files
------------

// File: rtl/xor4x4_share_arbiter_if.sv
// Requester/result bundle for the shared 4-lane XOR reducer.
// The arbiter takes the slave side; the requesters and the consumer drive the master side.
interface xor4x4_share_arbiter_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
);
  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ-1:0][15:0] req_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [3:0]            out_data;
  logic [IDW-1:0]        out_id;
  logic                  out_burst;

  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_id, out_burst
  );
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_id, out_burst
  );
endinterface

// File: rtl/xor4x4_share_arbiter.sv
// One 4-lane XOR reducer shared by NREQ requesters.
// Round-robin arbitration with bounded burst ownership feeds a single registered result slot.
module xor4x4_lane (
  input  logic [3:0] bits,
  output logic       o
);
  assign o = ^bits;
endmodule

module xor4x4_share_arbiter #(
  parameter int NREQ     = 4,
  parameter int IDW      = 2,
  parameter int MAXBURST = 4
) (
  input logic                  CLK,
  input logic                  ASYNCRESETN,
  xor4x4_share_arbiter_if.slave bus
);
  typedef enum logic {IDLE, BURST} state_t;

  state_t          state;
  logic [IDW-1:0]  ptr, owner, win;
  logic [3:0]      cnt;
  logic [NREQ-1:0] gnt;
  logic            can_accept, xfer;
  logic [15:0]     sel_data;
  logic [3:0]      red;

  // Reverse scan so the last hit is the first valid index at or after ptr.
  always_comb begin
    can_accept = ~bus.out_valid | bus.out_ready;
    gnt        = '0;
    win        = ptr;
    xfer       = 1'b0;
    if (ASYNCRESETN && can_accept) begin
      if (state == BURST) begin
        if (bus.req_valid[owner]) begin
          win  = owner;
          xfer = 1'b1;
        end
      end else begin
        for (int off = NREQ - 1; off >= 0; off--) begin
          if (bus.req_valid[(int'(ptr) + off) % NREQ]) begin
            win  = IDW'((int'(ptr) + off) % NREQ);
            xfer = 1'b1;
          end
        end
      end
      if (xfer) gnt[win] = 1'b1;
    end
  end

  assign bus.req_ready = gnt;
  assign sel_data      = bus.req_data[win];

  for (genvar k = 0; k < 4; k++) begin : g_lane
    xor4x4_lane u_lane (
      .bits({sel_data[12+k], sel_data[8+k], sel_data[4+k], sel_data[k]}),
      .o   (red[k])
    );
  end

  always_ff @(posedge CLK or negedge ASYNCRESETN) begin
    if (!ASYNCRESETN) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      cnt           <= '0;
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.out_id    <= '0;
      bus.out_burst <= 1'b0;
    end else if (xfer) begin
      bus.out_valid <= 1'b1;
      bus.out_data  <= red;
      bus.out_id    <= win;
      if (state == IDLE) begin
        ptr           <= (win == IDW'(NREQ - 1)) ? '0 : win + IDW'(1);
        owner         <= win;
        cnt           <= 4'd1;
        bus.out_burst <= 1'b0;
        state         <= (MAXBURST > 1) ? BURST : IDLE;
      end else begin
        cnt           <= cnt + 4'd1;
        bus.out_burst <= 1'b1;
        if (({1'b0, cnt} + 5'd1) == 5'(MAXBURST)) state <= IDLE;
      end
    end else begin
      if (bus.out_ready) bus.out_valid <= 1'b0;
      // Owner went quiet while the slot could take a beat: release ownership.
      if (state == BURST && can_accept) state <= IDLE;
    end
  end
endmodule

// File: tb/tb_xor4x4_share_arbiter.sv
// Scoreboard bench: two arbiters (MAXBURST 4 and 1) on shared stimulus; requesters follow dut_a grants.
module tb_xor4x4_share_arbiter;
  typedef struct packed {
    logic [3:0] data;
    logic [1:0] id;
    logic       burst;
  } beat_t;

  logic            CLK = 1'b0;
  logic            ASYNCRESETN;
  logic [3:0]      req_valid;
  logic [3:0][15:0] req_data;
  logic            out_ready;
  int              remain [4];
  int              checks = 0;
  int              failures = 0;
  beat_t           sbq_a[$], sbq_b[$], log_a[$], log_b[$];
  beat_t           ea, eb;
  logic [3:0]      gnt_hist[$];

  always #5 CLK = ~CLK;

  xor4x4_share_arbiter_if #(.NREQ(4), .IDW(2)) bus_a ();
  xor4x4_share_arbiter_if #(.NREQ(4), .IDW(2)) bus_b ();

  assign bus_a.req_valid = req_valid;
  assign bus_a.req_data  = req_data;
  assign bus_a.out_ready = out_ready;
  assign bus_b.req_valid = req_valid;
  assign bus_b.req_data  = req_data;
  assign bus_b.out_ready = out_ready;

  xor4x4_share_arbiter #(.NREQ(4), .IDW(2), .MAXBURST(4)) dut_a (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(bus_a));
  xor4x4_share_arbiter #(.NREQ(4), .IDW(2), .MAXBURST(1)) dut_b (
    .CLK(CLK), .ASYNCRESETN(ASYNCRESETN), .bus(bus_b));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [3:0] xr(input logic [15:0] d);
    return d[3:0] ^ d[7:4] ^ d[11:8] ^ d[15:12];
  endfunction

  // Monitors: sampled on the falling edge, pushing on transfer and popping on drain.
  always @(negedge CLK) if (ASYNCRESETN) begin
    if (bus_a.out_valid && out_ready) begin
      if (sbq_a.size() == 0) chk("sb_a_underflow", 1, 0);
      else begin
        ea = sbq_a.pop_front();
        chk("sb_a_data", bus_a.out_data, ea.data);
        chk("sb_a_id", bus_a.out_id, ea.id);
      end
      log_a.push_back('{bus_a.out_data, bus_a.out_id, bus_a.out_burst});
    end
    chk("rdy_a_legal", $onehot0(bus_a.req_ready) && ((bus_a.req_ready & ~req_valid) == 0) &&
        ((~bus_a.out_valid | out_ready) || bus_a.req_ready == 0), 1);
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && bus_a.req_ready[i]) sbq_a.push_back('{xr(req_data[i]), 2'(i), 1'b0});
  end

  always @(negedge CLK) if (ASYNCRESETN) begin
    if (bus_b.out_valid && out_ready) begin
      if (sbq_b.size() == 0) chk("sb_b_underflow", 1, 0);
      else begin
        eb = sbq_b.pop_front();
        chk("sb_b_data", bus_b.out_data, eb.data);
        chk("sb_b_id", bus_b.out_id, eb.id);
      end
      log_b.push_back('{bus_b.out_data, bus_b.out_id, bus_b.out_burst});
    end
    chk("rdy_b_legal", $onehot0(bus_b.req_ready) && ((bus_b.req_ready & ~req_valid) == 0) &&
        ((~bus_b.out_valid | out_ready) || bus_b.req_ready == 0), 1);
    for (int i = 0; i < 4; i++)
      if (req_valid[i] && bus_b.req_ready[i]) sbq_b.push_back('{xr(req_data[i]), 2'(i), 1'b0});
  end

  task automatic apply_valid();
    for (int i = 0; i < 4; i++) req_valid[i] = (remain[i] != 0);
  endtask

  task automatic clear_sb();
    sbq_a.delete(); sbq_b.delete(); log_a.delete(); log_b.delete(); gnt_hist.delete();
  endtask

  task automatic do_reset();
    for (int i = 0; i < 4; i++) remain[i] = 0;
    apply_valid();
    out_ready   = 1'b1;
    ASYNCRESETN = 1'b0;
    clear_sb();
    repeat (2) @(posedge CLK);
    #2 ASYNCRESETN = 1'b1;
  endtask

  // Requesters hold valid until their beat budget is spent; grants taken from dut_a.
  task automatic run_req(input int ncyc, input bit rnd);
    logic [3:0] g;
    apply_valid();
    for (int c = 0; c < ncyc; c++) begin
      @(negedge CLK);
      g = req_valid & bus_a.req_ready;
      gnt_hist.push_back(g);
      @(posedge CLK);
      #1;
      for (int i = 0; i < 4; i++)
        if (g[i]) begin
          remain[i]--;
          if (rnd) req_data[i] = 16'($urandom);
        end
      apply_valid();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 4; i++) remain[i] = 0;
    apply_valid();
    out_ready = 1'b1;
    repeat (4) @(posedge CLK);
    #1;
  endtask

  // Expected ids/bursts packed one nibble per beat, first beat in the most significant nibble.
  task automatic chk_log(input string tag, input bit use_b, input int n,
                         input logic [63:0] ids, input logic [63:0] bs);
    int sz;
    beat_t b;
    sz = use_b ? log_b.size() : log_a.size();
    chk({tag, "_len"}, sz, n);
    for (int k = 0; k < n && k < sz; k++) begin
      b = use_b ? log_b[k] : log_a[k];
      chk({tag, "_id"}, b.id, ids[4*(n-1-k) +: 4]);
      chk({tag, "_burst"}, b.burst, bs[4*(n-1-k) +: 4]);
    end
  endtask

  initial begin
    logic [3:0] d0;
    logic [1:0] i0;
    for (int i = 0; i < 4; i++) req_data[i] = 16'($urandom);
    req_valid   = 4'hF;
    out_ready   = 1'b0;
    ASYNCRESETN = 1'b0;
    #12;
    chk("rst_ready_a", bus_a.req_ready, 0);
    chk("rst_ready_b", bus_b.req_ready, 0);
    chk("rst_valid", {bus_a.out_valid, bus_b.out_valid}, 0);
    chk("rst_data", {bus_a.out_data, bus_b.out_data}, 0);
    chk("rst_id_burst", {bus_a.out_id, bus_a.out_burst, bus_b.out_id, bus_b.out_burst}, 0);

    // Single requester
    do_reset();
    remain[0] = 1;
    req_data[0] = 16'h1234;
    run_req(1, 0);
    chk("t1_valid", {bus_a.out_valid, bus_b.out_valid}, 2'b11);
    chk("t1_data_a", bus_a.out_data, 4'h4);
    chk("t1_data_b", bus_b.out_data, 4'h4);
    chk("t1_id", {bus_a.out_id, bus_b.out_id}, 0);
    drain();

    // All valid: MAXBURST=1 rotates every beat, MAXBURST=4 bursts then rotates
    do_reset();
    for (int i = 0; i < 4; i++) remain[i] = 100;
    run_req(5, 1);
    drain();
    chk_log("t2_b", 1, 5, 64'h01230, 64'h00000);
    chk_log("t2_a", 0, 5, 64'h00001, 64'h01110);

    // Long burst from req 2 is cut at MAXBURST, resumes after rotation
    do_reset();
    remain[2] = 6;
    run_req(1, 1);
    remain[0] = 1; remain[1] = 1; remain[3] = 1;
    run_req(12, 1);
    drain();
    chk_log("t3", 0, 9, 64'h222230122, 64'h011100001);

    // Backpressure with slot full
    do_reset();
    remain[0] = 6; remain[1] = 2;
    run_req(2, 1);
    out_ready = 1'b0;
    d0 = bus_a.out_data;
    i0 = bus_a.out_id;
    for (int c = 0; c < 3; c++) begin
      run_req(1, 1);
      chk("t4_ready_a", bus_a.req_ready, 0);
      chk("t4_ready_b", bus_b.req_ready, 0);
      chk("t4_hold", {bus_a.out_valid, bus_a.out_data, bus_a.out_id}, {1'b1, d0, i0});
    end
    out_ready = 1'b1;
    run_req(10, 1);
    drain();
    chk_log("t4", 0, 8, 64'h00001100, 64'h01110101);
    chk("t4_sb_empty", {sbq_a.size(), sbq_b.size()}, 0);

    // Owner drops valid mid-burst: one bubble, then round-robin from ptr
    do_reset();
    remain[0] = 2; req_data[0] = 16'hFFFF;
    remain[1] = 1; req_data[1] = 16'h000F;
    run_req(5, 0);
    chk("t5_gnt", {gnt_hist[0], gnt_hist[1], gnt_hist[2], gnt_hist[3], gnt_hist[4]}, 20'h11020);
    drain();
    chk_log("t5", 0, 3, 64'h001, 64'h010);
    if (log_a.size() == 3) chk("t5_data", {log_a[0].data, log_a[1].data, log_a[2].data}, 12'h00F);
    else chk("t5_data_len", log_a.size(), 3);

    // Asynchronous reset mid-burst
    do_reset();
    remain[0] = 10;
    run_req(2, 1);
    chk("t6_pre_valid", bus_a.out_valid, 1);
    #3 ASYNCRESETN = 1'b0;
    #1;
    chk("t6_rst_valid", {bus_a.out_valid, bus_b.out_valid}, 0);
    chk("t6_rst_ready", {bus_a.req_ready, bus_b.req_ready}, 0);
    clear_sb();
    for (int i = 0; i < 4; i++) remain[i] = 0;
    remain[1] = 1; remain[3] = 1;
    apply_valid();
    @(posedge CLK);
    #2 ASYNCRESETN = 1'b1;
    run_req(1, 0);
    chk("t6_first", {bus_a.out_valid, bus_a.out_id, bus_b.out_valid, bus_b.out_id}, {1'b1, 2'd1, 1'b1, 2'd1});
    run_req(4, 0);
    drain();
    chk("t6_sb_empty", {sbq_a.size(), sbq_b.size()}, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
